// File: rtl/spi_sb_pkg.sv
// Shared definitions for the SB_SPI byte link: system-bus register map,
// SPISR bit positions, the link FSM state type and the bus request record.
package spi_sb_pkg;

    // SB_SPI system-bus register addresses
    localparam logic [7:0] ADR_CR0  = 8'h08;
    localparam logic [7:0] ADR_CR1  = 8'h09;
    localparam logic [7:0] ADR_CR2  = 8'h0A;
    localparam logic [7:0] ADR_BR   = 8'h0B;
    localparam logic [7:0] ADR_SR   = 8'h0C;
    localparam logic [7:0] ADR_TXDR = 8'h0D;
    localparam logic [7:0] ADR_RXDR = 8'h0E;
    localparam logic [7:0] ADR_CSR  = 8'h0F;

    // SPISR bit indices
    localparam int SR_TIP  = 7;
    localparam int SR_BUSY = 6;
    localparam int SR_TRDY = 4;
    localparam int SR_RRDY = 3;
    localparam int SR_ROE  = 1;

    // Values written during the init sequence that are not parameters
    localparam logic [7:0] CR0_VAL = 8'h00;
    localparam logic [7:0] CR1_VAL = 8'h80;  // enable the SPI core
    localparam logic [7:0] CSR_VAL = 8'h00;

    localparam logic SB_WR = 1'b1;
    localparam logic SB_RD = 1'b0;

    typedef enum logic [2:0] {
        ST_CFG_CR0,
        ST_CFG_CR1,
        ST_CFG_CR2,
        ST_CFG_BR,
        ST_CFG_CSR,
        ST_POLL,
        ST_RD_RX,
        ST_WR_TX
    } link_state_t;

    // One system-bus access as held on the SB pins while the strobe is high
    typedef struct packed {
        logic       rw;
        logic [7:0] adr;
        logic [7:0] dat;
    } sb_req_t;

    // Config states retry the same register after a timeout
    function automatic logic is_cfg(input link_state_t s);
        return s inside {ST_CFG_CR0, ST_CFG_CR1, ST_CFG_CR2, ST_CFG_BR, ST_CFG_CSR};
    endfunction

endpackage

// File: rtl/spi_byte_fifo.sv
// Byte FIFO used as the rx buffer when SPI_RX_FIFO_EN is defined.
// Head entry is presented combinationally; push and pop in one cycle are
// both honoured, including push while full when a pop frees the slot.
module spi_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic w_pop;
    logic w_push;

    assign empty  = (r_count == '0);
    assign full   = (r_count == (AW+1)'(DEPTH));
    assign w_pop  = pop & ~empty;
    assign w_push = push & (~full | w_pop);
    // Gate to zero while empty so the output never shows a stale entry
    assign dout   = empty ? 8'h00 : r_mem[r_rd_ptr];

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Pointer and occupancy bookkeeping
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array write port
    // NOTE: the array has no reset; validity is tracked by r_count, and
    // leaving it unreset lets synthesis map it to plain storage.
    always_ff @(posedge CLK) begin
        if (w_push) r_mem[r_wr_ptr] <= din;
    end

endmodule

// File: rtl/spi_sb_byte_link.sv
// SB_SPI system-bus byte link: runs the register init sequence, polls SPISR,
// drains SPIRXDR into an rx buffer and writes held tx bytes to SPITXDR,
// presenting valid/ready byte streams to the command layer.
// Build option: SPI_RX_FIFO_EN selects a FIFO_DEPTH-entry rx FIFO
// (spi_byte_fifo) instead of the default single-byte rx register.
module spi_sb_byte_link
    import spi_sb_pkg::*;
#(
    parameter logic [7:0] CR2_VAL     = 8'h01,
    parameter logic [7:0] BR_VAL      = 8'h00,
    parameter int         ACK_TIMEOUT = 16,
    parameter int         FIFO_DEPTH  = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    output logic       sb_stb,
    output logic       sb_rw,
    output logic [7:0] sb_adr,
    output logic [7:0] sb_dati,
    input  logic [7:0] sb_dato,
    input  logic       sb_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       init_done,
    output logic       rx_overrun,
    output logic       bus_err,
    input  logic       err_clr
);

    localparam int TO_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;

    // Bus access state
    link_state_t   r_state;
    logic          r_stb;
    sb_req_t       r_req;
    logic [TO_W-1:0] r_to_cnt;

    link_state_t   w_state_nxt;
    logic          w_stb_nxt;
    sb_req_t       w_req_nxt;
    logic [TO_W-1:0] w_to_cnt_nxt;

    // Events produced by the FSM for the datapath registers
    logic w_rx_push;
    logic w_tx_free;
    logic w_set_roe;
    logic w_set_berr;
    logic w_init_set;
    logic w_rx_space;
    logic w_tx_ready;

    // Status and tx holding register
    logic       r_init_done;
    logic       r_rx_overrun;
    logic       r_bus_err;
    logic       r_tx_full;
    logic [7:0] r_tx_data;

    assign sb_stb     = r_stb;
    assign sb_rw      = r_req.rw;
    assign sb_adr     = r_req.adr;
    assign sb_dati    = r_req.dat;
    assign init_done  = r_init_done;
    assign rx_overrun = r_rx_overrun;
    assign bus_err    = r_bus_err;
    assign w_tx_ready = r_init_done & ~r_tx_full;
    assign tx_ready   = w_tx_ready;

    // FSM state register together with the registered SB pins
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state  <= ST_CFG_CR0;
            r_stb    <= 1'b0;
            r_req    <= '0;
            r_to_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_stb    <= w_stb_nxt;
            r_req    <= w_req_nxt;
            r_to_cnt <= w_to_cnt_nxt;
        end
    end

    // Next-state logic: issue an access whenever the strobe is idle, finish it on ack or timeout
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // can leave one unassigned and infer a latch.
        w_state_nxt  = r_state;
        w_stb_nxt    = r_stb;
        w_req_nxt    = r_req;
        w_to_cnt_nxt = r_to_cnt;
        w_rx_push    = 1'b0;
        w_tx_free    = 1'b0;
        w_set_roe    = 1'b0;
        w_set_berr   = 1'b0;
        w_init_set   = 1'b0;

        if (!r_stb) begin
            // Strobe was low for this cycle: launch the access for the current state
            w_stb_nxt    = 1'b1;
            w_to_cnt_nxt = '0;
            case (r_state)
                ST_CFG_CR0: w_req_nxt = '{rw: SB_WR, adr: ADR_CR0,  dat: CR0_VAL};
                ST_CFG_CR1: w_req_nxt = '{rw: SB_WR, adr: ADR_CR1,  dat: CR1_VAL};
                ST_CFG_CR2: w_req_nxt = '{rw: SB_WR, adr: ADR_CR2,  dat: CR2_VAL};
                ST_CFG_BR:  w_req_nxt = '{rw: SB_WR, adr: ADR_BR,   dat: BR_VAL};
                ST_CFG_CSR: w_req_nxt = '{rw: SB_WR, adr: ADR_CSR,  dat: CSR_VAL};
                ST_RD_RX:   w_req_nxt = '{rw: SB_RD, adr: ADR_RXDR, dat: 8'h00};
                ST_WR_TX:   w_req_nxt = '{rw: SB_WR, adr: ADR_TXDR, dat: r_tx_data};
                default:    w_req_nxt = '{rw: SB_RD, adr: ADR_SR,   dat: 8'h00};
            endcase
        end else if (sb_ack) begin
            w_stb_nxt = 1'b0;
            case (r_state)
                ST_CFG_CR0: w_state_nxt = ST_CFG_CR1;
                ST_CFG_CR1: w_state_nxt = ST_CFG_CR2;
                ST_CFG_CR2: w_state_nxt = ST_CFG_BR;
                ST_CFG_BR:  w_state_nxt = ST_CFG_CSR;
                ST_CFG_CSR: begin
                    w_state_nxt = ST_POLL;
                    w_init_set  = 1'b1;
                end
                ST_RD_RX: begin
                    w_rx_push   = 1'b1;
                    w_state_nxt = ST_POLL;
                end
                ST_WR_TX: begin
                    w_tx_free   = 1'b1;
                    w_state_nxt = ST_POLL;
                end
                default: begin
                    // SPISR returned: rx drains before tx, and only into free space
                    w_set_roe = sb_dato[SR_ROE];
                    if (sb_dato[SR_RRDY] && w_rx_space) begin
                        w_state_nxt = ST_RD_RX;
                    end else if (sb_dato[SR_TRDY] && r_tx_full) begin
                        w_state_nxt = ST_WR_TX;
                    end else begin
                        w_state_nxt = ST_POLL;
                    end
                end
            endcase
        end else if (r_to_cnt == TO_W'(ACK_TIMEOUT - 1)) begin
            // Strobe has been high ACK_TIMEOUT cycles: abandon the access
            w_stb_nxt  = 1'b0;
            w_set_berr = 1'b1;
            if (!is_cfg(r_state)) w_state_nxt = ST_POLL;
        end else begin
            w_to_cnt_nxt = r_to_cnt + 1'b1;
        end
    end

    // Sticky error flags and init completion; a new error beats err_clr
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_init_done  <= 1'b0;
            r_rx_overrun <= 1'b0;
            r_bus_err    <= 1'b0;
        end else begin
            if (w_init_set) r_init_done <= 1'b1;

            if (w_set_roe)    r_rx_overrun <= 1'b1;
            else if (err_clr) r_rx_overrun <= 1'b0;

            if (w_set_berr)   r_bus_err <= 1'b1;
            else if (err_clr) r_bus_err <= 1'b0;
        end
    end

    // One-byte tx holding register; a byte abandoned by a timeout stays held for retry
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_tx_full <= 1'b0;
            r_tx_data <= 8'h00;
        end else if (tx_valid && w_tx_ready) begin
            r_tx_full <= 1'b1;
            r_tx_data <= tx_data;
        end else if (w_tx_free) begin
            r_tx_full <= 1'b0;
        end
    end

`ifdef SPI_RX_FIFO_EN
    logic w_fifo_empty;
    logic w_fifo_full;

    spi_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .CLK   (CLK),
        .RST_N (RST_N),
        .push  (w_rx_push),
        .din   (sb_dato),
        .pop   (rx_ready),
        .dout  (rx_data),
        .empty (w_fifo_empty),
        .full  (w_fifo_full)
    );

    assign rx_valid   = ~w_fifo_empty;
    assign w_rx_space = ~w_fifo_full;
`else
    logic [7:0] r_rx_data;
    logic       r_rx_full;

    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_full;
    assign w_rx_space = ~r_rx_full;

    // Single-byte rx register; a push in the same cycle as a pop keeps it full
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_rx_data <= 8'h00;
            r_rx_full <= 1'b0;
        end else if (w_rx_push) begin
            r_rx_data <= sb_dato;
            r_rx_full <= 1'b1;
        end else if (r_rx_full && rx_ready) begin
            r_rx_full <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_spi_sb_byte_link.sv
// Directed bench for spi_sb_byte_link with a behavioural SB_SPI register model
// (configurable ack delay, ack hold-off, rx byte source and TXDR sink).
module tb_spi_sb_byte_link;
    import spi_sb_pkg::*;

    localparam int ACK_TIMEOUT = 16;
`ifdef SPI_RX_FIFO_EN
    localparam int RX_CAP = 4;
`else
    localparam int RX_CAP = 1;
`endif
    localparam int LOG_MAX = 2048;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       sb_stb;
    logic       sb_rw;
    logic [7:0] sb_adr;
    logic [7:0] sb_dati;
    logic [7:0] sb_dato = 8'h00;
    logic       sb_ack = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       init_done;
    logic       rx_overrun;
    logic       bus_err;
    logic       err_clr;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    spi_sb_byte_link #(
        .CR2_VAL     (8'h01),
        .BR_VAL      (8'h00),
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .FIFO_DEPTH  (4)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .sb_stb     (sb_stb),
        .sb_rw      (sb_rw),
        .sb_adr     (sb_adr),
        .sb_dati    (sb_dati),
        .sb_dato    (sb_dato),
        .sb_ack     (sb_ack),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .init_done  (init_done),
        .rx_overrun (rx_overrun),
        .bus_err    (bus_err),
        .err_clr    (err_clr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- SB_SPI register model ----------------
    int         ack_delay = 1;
    bit         ack_hold  = 1'b0;
    int         wait_cnt  = 0;
    int         rx_loaded = 0;      // bytes the bench has made available
    int         rx_reads  = 0;      // RXDR reads performed
    logic [7:0] rx_base   = 8'h00;  // RXDR returns rx_base + read index
    bit         sr_trdy   = 1'b0;
    bit         sr_roe    = 1'b0;
    int         tx_writes = 0;
    logic [7:0] last_tx   = 8'h00;
    logic [7:0] log_adr [LOG_MAX];
    logic       log_rw  [LOG_MAX];
    logic [7:0] log_dat [LOG_MAX];
    int         log_n = 0;

    always @(posedge CLK) begin
        sb_ack <= 1'b0;
        if (sb_stb && !sb_ack) begin
            if (!ack_hold && (wait_cnt + 1 >= ack_delay)) begin
                sb_ack   <= 1'b1;
                wait_cnt <= 0;
                if (log_n < LOG_MAX) begin
                    log_adr[log_n] <= sb_adr;
                    log_rw[log_n]  <= sb_rw;
                    log_dat[log_n] <= sb_dati;
                end
                log_n   <= log_n + 1;
                sb_dato <= 8'h00;
                if (!sb_rw && sb_adr == ADR_SR) begin
                    sb_dato <= {3'b000, sr_trdy, (rx_loaded > rx_reads), 1'b0, sr_roe, 1'b0};
                end else if (!sb_rw && sb_adr == ADR_RXDR) begin
                    sb_dato  <= rx_base + 8'(rx_reads);
                    rx_reads <= rx_reads + 1;
                end else if (sb_rw && sb_adr == ADR_TXDR) begin
                    tx_writes <= tx_writes + 1;
                    last_tx   <= sb_dati;
                end
            end else begin
                wait_cnt <= wait_cnt + 1;
            end
        end else begin
            wait_cnt <= 0;
        end
    end

    // Strobe must be low in the cycle after every acknowledged access
    bit ack_seen = 1'b0;
    always @(negedge CLK) begin
        if (ack_seen) check("stb_low_after_ack", sb_stb, 1'b0);
        ack_seen = sb_ack && sb_stb;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=still_running expected=finished");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    logic [7:0] cfg_adr [5];
    logic [7:0] cfg_dat [5];

    initial begin
        int n0;
        int mark;
        int rd_idx;
        int wr_idx;
        int hi_cnt;

        cfg_adr = '{8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0F};
        cfg_dat = '{8'h00, 8'h80, 8'h01, 8'h00, 8'h00};

        RST_N    = 1'b0;
        rx_ready = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        err_clr  = 1'b0;
        repeat (3) @(negedge CLK);

        // Reset state
        check("rst_sb_stb", sb_stb, 1'b0);
        check("rst_init_done", init_done, 1'b0);
        check("rst_tx_ready", tx_ready, 1'b0);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_bus_err", bus_err, 1'b0);
        check("rst_rx_overrun", rx_overrun, 1'b0);

        // Init sequence: five writes, init_done the cycle after the fifth ack
        RST_N = 1'b1;
        for (int i = 0; i < 100 && !init_done; i++) @(negedge CLK);
        check("init_done_rise", init_done, 1'b1);
        check("init_access_count", log_n, 5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("cfg%0d_adr", i), log_adr[i], cfg_adr[i]);
            check($sformatf("cfg%0d_rw", i), log_rw[i], 1'b1);
            check($sformatf("cfg%0d_dat", i), log_dat[i], cfg_dat[i]);
        end
        check("tx_ready_after_init", tx_ready, 1'b1);

        // Single rx byte 0xA5 with consumer ready
        n0        = rx_reads;
        rx_base   = 8'hA5 - 8'(rx_reads);
        rx_ready  = 1'b1;
        rx_loaded = rx_reads + 1;
        for (int i = 0; i < 50 && !rx_valid; i++) @(negedge CLK);
        check("rx_valid_rise", rx_valid, 1'b1);
        check("rx_data_a5", rx_data, 8'hA5);
        @(negedge CLK);
        check("rx_valid_one_cycle", rx_valid, 1'b0);
        repeat (20) @(negedge CLK);
        check("rx_single_read", rx_reads - n0, 1);

        // tx byte 0x3C, held until TRDY, ack delay 2
        ack_delay = 2;
        tx_data   = 8'h3C;
        tx_valid  = 1'b1;
        @(negedge CLK);
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        check("tx_ready_low_after_load", tx_ready, 1'b0);
        n0 = tx_writes;
        repeat (12) @(negedge CLK);
        check("tx_held_without_trdy", tx_writes - n0, 0);
        sr_trdy = 1'b1;
        for (int i = 0; i < 60 && tx_writes == n0; i++) @(negedge CLK);
        check("txdr_write_count", tx_writes - n0, 1);
        check("txdr_value_3c", last_tx, 8'h3C);
        check("tx_ready_low_until_ack", tx_ready, 1'b0);
        @(negedge CLK);
        check("tx_ready_high_after_ack", tx_ready, 1'b1);
        sr_trdy   = 1'b0;
        ack_delay = 1;
        repeat (4) @(negedge CLK);

        // SR = 0x18 with a tx byte held: RXDR read precedes TXDR write
        tx_data  = 8'h5A;
        tx_valid = 1'b1;
        @(negedge CLK);
        tx_valid  = 1'b0;
        mark      = log_n;
        n0        = tx_writes;
        rx_base   = 8'h77 - 8'(rx_reads);
        rx_loaded = rx_reads + 1;
        sr_trdy   = 1'b1;
        for (int i = 0; i < 60 && tx_writes == n0; i++) @(negedge CLK);
        rd_idx = -1;
        wr_idx = LOG_MAX;
        for (int j = mark; j < log_n && j < LOG_MAX; j++) begin
            if (rd_idx < 0 && !log_rw[j] && log_adr[j] == ADR_RXDR) rd_idx = j;
            if (wr_idx == LOG_MAX && log_rw[j] && log_adr[j] == ADR_TXDR) wr_idx = j;
        end
        check("prio_rx_read_seen", rd_idx >= 0, 1'b1);
        check("prio_rx_before_tx", rd_idx < wr_idx, 1'b1);
        check("prio_tx_value_5a", last_tx, 8'h5A);
        sr_trdy = 1'b0;
        repeat (6) @(negedge CLK);

        // Backpressure: consumer stalled, eight bytes offered
        rx_ready  = 1'b0;
        n0        = rx_reads;
        rx_base   = 8'h10 - 8'(rx_reads);
        rx_loaded = rx_reads + 8;
        repeat (80) @(negedge CLK);
        check("bp_reads_while_full", rx_reads - n0, RX_CAP);
        check("bp_rx_valid", rx_valid, 1'b1);
        check("bp_head_10", rx_data, 8'h10);
        rx_ready = 1'b1;
        @(negedge CLK);
        rx_ready = 1'b0;
        repeat (60) @(negedge CLK);
        check("bp_one_more_read", rx_reads - n0, RX_CAP + 1);
        check("bp_head_11", rx_data, 8'h11);
        rx_loaded = rx_reads;
        rx_ready  = 1'b1;
        repeat (30) @(negedge CLK);
        check("bp_drained", rx_valid, 1'b0);

        // ROE: sticky, err_clr coinciding with a fresh ROE loses, then clears
        sr_roe = 1'b1;
        repeat (15) @(negedge CLK);
        check("roe_set", rx_overrun, 1'b1);
        for (int i = 0; i < 30 && !(sb_ack && sb_stb && sb_adr == ADR_SR); i++) @(negedge CLK);
        err_clr = 1'b1;
        @(negedge CLK);
        err_clr = 1'b0;
        check("roe_wins_over_clr", rx_overrun, 1'b1);
        sr_roe = 1'b0;
        repeat (10) @(negedge CLK);
        check("roe_sticky", rx_overrun, 1'b1);
        err_clr = 1'b1;
        @(negedge CLK);
        err_clr = 1'b0;
        check("roe_cleared", rx_overrun, 1'b0);

        // Ack withheld: strobe held exactly ACK_TIMEOUT cycles, bus_err set
        ack_hold = 1'b1;
        for (int i = 0; i < 40 && sb_stb; i++) @(negedge CLK);
        for (int i = 0; i < 5 && !sb_stb; i++) @(negedge CLK);
        hi_cnt = 0;
        while (sb_stb && hi_cnt < 100) begin
            hi_cnt++;
            @(negedge CLK);
        end
        check("timeout_stb_cycles", hi_cnt, ACK_TIMEOUT);
        check("bus_err_set", bus_err, 1'b1);
        ack_hold = 1'b0;
        repeat (6) @(negedge CLK);
        check("bus_err_sticky", bus_err, 1'b1);
        err_clr = 1'b1;
        @(negedge CLK);
        err_clr = 1'b0;
        check("bus_err_cleared", bus_err, 1'b0);

        // Reset in the middle of an access
        for (int i = 0; i < 10 && !sb_stb; i++) @(negedge CLK);
        check("pre_reset_stb_high", sb_stb, 1'b1);
        RST_N = 1'b0;
        #1;
        check("rst_async_stb", sb_stb, 1'b0);
        check("rst_async_init_done", init_done, 1'b0);
        check("rst_async_tx_ready", tx_ready, 1'b0);
        @(negedge CLK);
        mark  = log_n;
        RST_N = 1'b1;
        for (int i = 0; i < 100 && !init_done; i++) @(negedge CLK);
        check("restart_init_done", init_done, 1'b1);
        check("restart_count", log_n - mark, 5);
        if (mark < LOG_MAX) begin
            check("restart_first_adr", log_adr[mark], ADR_CR0);
            check("restart_first_dat", log_dat[mark], 8'h00);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
